hub75_column_feeder: RTL and testbench

- Upstream producer for the HUB75 column driver. On each new rotation angle it reads one column of pixel data from frame-buffer BRAM.
- It reads two halves of NUM_ROWS pixels each, packs them into the driver's column_data bus, and offers them over a tvalid/tready handshake.
- It sits between the angle/rotation tracker and the HUB75 output driver. It owns the BRAM read port.

---
 rtl/hub75_column_feeder_if.sv | 28 ++
 rtl/hub75_column_feeder.sv | 199 +++++++++++++++++++
 tb/tb_hub75_column_feeder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_column_feeder_if.sv
// Column stream from the feeder to the HUB75 output driver.
// The master side owns column_data/theta_out/tvalid; the slave side owns tready.
interface hub75_column_feeder_if #(
    parameter int unsigned ROTATIONAL_RES = 1024,
    parameter int unsigned NUM_ROWS       = 64,
    parameter int unsigned RGB_RES        = 9
);
    localparam int unsigned THETA_W = $clog2(ROTATIONAL_RES);

    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] column_data;
    logic [THETA_W-1:0]                    theta_out;
    logic                                  tvalid;
    logic                                  tready;

    modport master (
        output column_data,
        output theta_out,
        output tvalid,
        input  tready
    );

    modport slave (
        input  column_data,
        input  theta_out,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/hub75_column_feeder.sv
// Fetches one 2*NUM_ROWS-pixel column from frame-buffer BRAM per requested angle
// and presents it to the HUB75 driver over a tvalid/tready handshake.
module hub75_column_feeder #(
    parameter int unsigned ROTATIONAL_RES = 1024,
    parameter int unsigned NUM_ROWS       = 64,
    parameter int unsigned RGB_RES        = 9,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned OVR_W          = 16,
    localparam int unsigned THETA_W = $clog2(ROTATIONAL_RES),
    localparam int unsigned ADDR_W  = $clog2(ROTATIONAL_RES * 2 * NUM_ROWS)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [THETA_W-1:0]    theta_in,
    input  logic                  theta_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd_en,
    input  logic [RGB_RES-1:0]    mem_data,
    hub75_column_feeder_if.master col_if,
    output logic                  busy,
    output logic [OVR_W-1:0]      overrun_count
);

    localparam int unsigned NUM_PIX = 2 * NUM_ROWS;
    localparam int unsigned IDX_W   = $clog2(NUM_PIX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } state_e;

    // Flat pixel index doubles as the (h,r) tag: idx = h*NUM_ROWS + r.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_e                            state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [ADDR_W-1:0]                 mem_addr_q, mem_addr_d;
    logic                              mem_rd_en_q, mem_rd_en_d;
    logic [THETA_W-1:0]                cur_theta_q, cur_theta_d;
    logic [THETA_W-1:0]                pending_theta_q, pending_theta_d;
    logic                              pending_q, pending_d;
    logic [THETA_W-1:0]                theta_out_q, theta_out_d;
    logic                              tvalid_q, tvalid_d;
    logic                              busy_q, busy_d;
    logic [OVR_W-1:0]                  ovr_q, ovr_d;
    tag_t [READ_LATENCY-1:0]           tag_q, tag_d;
    logic [NUM_PIX-1:0][RGB_RES-1:0]   stage_q, stage_d;
    logic [NUM_PIX-1:0][RGB_RES-1:0]   column_q, column_d;

    logic               handshake;
    logic               have_req;
    logic [THETA_W-1:0] req_theta;
    tag_t               tag_out;
    logic               last_cap;
    logic               start;

    assign handshake = tvalid_q && col_if.tready;
    assign have_req  = pending_q || theta_valid;
    assign req_theta = theta_valid ? theta_in : pending_theta_q;
    assign tag_out   = tag_q[READ_LATENCY-1];
    assign last_cap  = tag_out.vld && (tag_out.idx == IDX_W'(NUM_PIX - 1));

    // Next-state, datapath and output computation.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        mem_addr_d      = mem_addr_q;
        mem_rd_en_d     = 1'b0;
        cur_theta_d     = cur_theta_q;
        pending_theta_d = pending_theta_q;
        pending_d       = pending_q;
        theta_out_d     = theta_out_q;
        tvalid_d        = tvalid_q;
        ovr_d           = ovr_q;
        stage_d         = stage_q;
        column_d        = column_q;
        start           = 1'b0;

        tag_d[0].vld = mem_rd_en_q;
        tag_d[0].idx = idx_q;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (tag_out.vld && !rst_in) begin
            stage_d[tag_out.idx] = mem_data;
        end

        case (state_q)
            IDLE: begin
                if (have_req) begin
                    start = 1'b1;
                end
            end
            FETCH: begin
                if (idx_q == IDX_W'(NUM_PIX - 1)) begin
                    state_d = DRAIN;
                end else begin
                    mem_rd_en_d = 1'b1;
                    idx_d       = idx_q + IDX_W'(1);
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Forward the final capture so tvalid rises the cycle after it lands.
                if (last_cap) begin
                    column_d    = stage_d;
                    theta_out_d = cur_theta_q;
                    tvalid_d    = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    tvalid_d = 1'b0;
                    if (have_req) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d     = FETCH;
            cur_theta_d = req_theta;
            mem_rd_en_d = 1'b1;
            idx_d       = '0;
            mem_addr_d  = ADDR_W'(req_theta) * ADDR_W'(NUM_PIX);
        end

        // Latest strobe wins; an unconsumed older one counts as an overrun.
        if (theta_valid) begin
            pending_d       = 1'b1;
            pending_theta_d = theta_in;
            if (pending_q && !start && (ovr_q != '1)) begin
                ovr_d = ovr_q + OVR_W'(1);
            end
        end
        if (start) begin
            pending_d = 1'b0;
        end

        busy_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            mem_addr_q      <= '0;
            mem_rd_en_q     <= 1'b0;
            cur_theta_q     <= '0;
            pending_theta_q <= '0;
            pending_q       <= 1'b0;
            theta_out_q     <= '0;
            tvalid_q        <= 1'b0;
            busy_q          <= 1'b0;
            ovr_q           <= '0;
            tag_q           <= '0;
            column_q        <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            mem_addr_q      <= mem_addr_d;
            mem_rd_en_q     <= mem_rd_en_d;
            cur_theta_q     <= cur_theta_d;
            pending_theta_q <= pending_theta_d;
            pending_q       <= pending_d;
            theta_out_q     <= theta_out_d;
            tvalid_q        <= tvalid_d;
            busy_q          <= busy_d;
            ovr_q           <= ovr_d;
            tag_q           <= tag_d;
            column_q        <= column_d;
        end
    end

    // Staging buffer needs no reset: every entry is rewritten before it is presented.
    always_ff @(posedge clk_in) begin
        stage_q <= stage_d;
    end

    assign mem_addr           = mem_addr_q;
    assign mem_rd_en          = mem_rd_en_q;
    assign busy               = busy_q;
    assign overrun_count      = ovr_q;
    assign col_if.column_data = column_q;
    assign col_if.theta_out   = theta_out_q;
    assign col_if.tvalid      = tvalid_q;

endmodule

// File: tb/tb_hub75_column_feeder.sv
// Scoreboard bench for hub75_column_feeder: BRAM returns addr[8:0] after RD_LAT cycles.
module tb_hub75_column_feeder;

    localparam int unsigned ROT    = 1024;
    localparam int unsigned NR     = 64;
    localparam int unsigned RGB    = 9;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned OVR_W  = 16;
    localparam int unsigned TW     = $clog2(ROT);
    localparam int unsigned NPIX   = 2 * NR;
    localparam int unsigned AW     = $clog2(ROT * NPIX);
    localparam int unsigned COL_W  = NPIX * RGB;
    localparam int          LAT    = NPIX + RD_LAT + 1;
    localparam int          BOUND  = 2000;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [TW-1:0]     theta_in;
    logic              theta_valid;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd_en;
    logic [RGB-1:0]    mem_data;
    logic              busy;
    logic [OVR_W-1:0]  overrun_count;
    int                cyc = 0;

    hub75_column_feeder_if #(.ROTATIONAL_RES(ROT), .NUM_ROWS(NR), .RGB_RES(RGB)) col_if ();

    hub75_column_feeder #(
        .ROTATIONAL_RES(ROT), .NUM_ROWS(NR), .RGB_RES(RGB),
        .READ_LATENCY(RD_LAT), .OVR_W(OVR_W)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .theta_in      (theta_in),
        .theta_valid   (theta_valid),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_data      (mem_data),
        .col_if        (col_if),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // BRAM model: data = low RGB bits of the address, not reset (late returns survive).
    logic [RGB-1:0] bram_pipe [RD_LAT];
    always @(posedge clk_in) begin
        bram_pipe[0] <= mem_rd_en ? RGB'(mem_addr) : '0;
        for (int i = 1; i < int'(RD_LAT); i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign mem_data = bram_pipe[RD_LAT-1];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [COL_W-1:0] obs, input logic [COL_W-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [COL_W-1:0] model_col(input int unsigned th);
        logic [COL_W-1:0] c;
        logic [AW-1:0]    a;
        c = '0;
        for (int unsigned i = 0; i < NPIX; i++) begin
            a = AW'(th * NPIX + i);
            c[i*RGB +: RGB] = RGB'(a);
        end
        return c;
    endfunction

    int unsigned exp_col_q[$];
    int unsigned exp_fetch_q[$];

    task automatic expect_col(input int unsigned th);
        exp_col_q.push_back(th);
        exp_fetch_q.push_back(th);
    endtask

    // Output monitor: address sequence, presentation stability, column scoreboard.
    logic             prev_rd = 1'b0;
    logic             presented = 1'b0;
    int unsigned      fetch_theta = 0;
    int unsigned      issue_cnt = 0;
    logic [AW-1:0]    exp_addr = '0;
    logic [AW-1:0]    last_addr = '0;
    int               last_issue_cyc = -1;
    logic [COL_W-1:0] hold_col = '0;
    logic [TW-1:0]    hold_theta = '0;
    int unsigned      th_pop;

    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_rd   = 1'b0;
            presented = 1'b0;
            issue_cnt = 0;
        end else begin
            if (mem_rd_en) begin
                if (!prev_rd) begin
                    check_eq("fetch_expected", COL_W'(1'(exp_fetch_q.size() != 0)), COL_W'(1'b1));
                    if (exp_fetch_q.size() != 0) fetch_theta = exp_fetch_q.pop_front();
                    exp_addr  = AW'(fetch_theta * NPIX);
                    issue_cnt = 0;
                end
                check_eq("mem_addr", COL_W'(mem_addr), COL_W'(exp_addr));
                exp_addr       = exp_addr + AW'(1);
                issue_cnt      = issue_cnt + 1;
                last_addr      = mem_addr;
                last_issue_cyc = cyc;
            end else if (prev_rd) begin
                check_eq("issue_count", COL_W'(issue_cnt), COL_W'(NPIX));
            end
            prev_rd = mem_rd_en;

            if (presented) begin
                check_eq("tvalid_hold", COL_W'(col_if.tvalid), COL_W'(1'b1));
                check_eq("col_stable", COL_W'(col_if.column_data), hold_col);
                check_eq("theta_stable", COL_W'(col_if.theta_out), COL_W'(hold_theta));
            end else if (col_if.tvalid) begin
                presented  = 1'b1;
                hold_col   = COL_W'(col_if.column_data);
                hold_theta = col_if.theta_out;
            end

            if (col_if.tvalid && col_if.tready) begin
                check_eq("col_expected", COL_W'(1'(exp_col_q.size() != 0)), COL_W'(1'b1));
                th_pop = (exp_col_q.size() != 0) ? exp_col_q.pop_front() : 0;
                check_eq("theta_out", COL_W'(col_if.theta_out), COL_W'(TW'(th_pop)));
                check_eq("column", COL_W'(col_if.column_data), model_col(th_pop));
                presented = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobe(input int unsigned th, output int t);
        theta_in    = TW'(th);
        theta_valid = 1'b1;
        t           = cyc;
        tick();
        theta_valid = 1'b0;
    endtask

    task automatic wait_rd(output int c);
        c = -1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk_in);
            if (mem_rd_en) begin c = cyc; break; end
        end
    endtask

    task automatic wait_tv(output int c);
        c = -1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk_in);
            if (col_if.tvalid) begin c = cyc; break; end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tvalid"}, COL_W'(col_if.tvalid), COL_W'(1'b0));
        check_eq({tag, "_rd_en"}, COL_W'(mem_rd_en), COL_W'(1'b0));
        check_eq({tag, "_addr"}, COL_W'(mem_addr), COL_W'(0));
        check_eq({tag, "_column"}, COL_W'(col_if.column_data), COL_W'(0));
        check_eq({tag, "_theta_out"}, COL_W'(col_if.theta_out), COL_W'(0));
        check_eq({tag, "_busy"}, COL_W'(busy), COL_W'(1'b0));
        check_eq({tag, "_ovr"}, COL_W'(overrun_count), COL_W'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, h, d;
        rst_in        = 1'b1;
        theta_valid   = 1'b0;
        theta_in      = '0;
        col_if.tready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_in = 1'b0;
        tick();

        // Basic fetch of theta=5 with an always-ready driver.
        expect_col(5);
        strobe(5, t);
        wait_rd(c);
        check_eq("a_first_rd", COL_W'(c), COL_W'(t + 1));
        check_eq("a_busy_fetch", COL_W'(busy), COL_W'(1'b1));
        wait_tv(c);
        check_eq("a_tvalid_lat", COL_W'(c), COL_W'(t + LAT));
        check_eq("a_last_issue", COL_W'(last_issue_cyc), COL_W'(t + int'(NPIX)));
        check_eq("a_pix00", COL_W'(col_if.column_data[0][0]), COL_W'(9'd128));
        check_eq("a_pix1_63", COL_W'(col_if.column_data[1][NR-1]), COL_W'(9'd255));
        check_eq("a_theta", COL_W'(col_if.theta_out), COL_W'(TW'(5)));
        check_eq("a_busy_present", COL_W'(busy), COL_W'(1'b0));
        tick();
        check_eq("a_tvalid_drop", COL_W'(col_if.tvalid), COL_W'(1'b0));

        // Back-pressure: 500 stalled cycles then a single transfer.
        col_if.tready = 1'b0;
        expect_col(20);
        strobe(20, t);
        wait_tv(c);
        check_eq("b_tvalid_lat", COL_W'(c), COL_W'(t + LAT));
        tick();
        repeat (500) tick();
        col_if.tready = 1'b1;
        tick();
        check_eq("b_tvalid_drop", COL_W'(col_if.tvalid), COL_W'(1'b0));
        check_eq("b_idle_busy", COL_W'(busy), COL_W'(1'b0));

        // Overrun: 7 starts a fetch, 9 and 11 arrive during it; 11 must win.
        col_if.tready = 1'b0;
        expect_col(7);
        strobe(7, t);
        wait_rd(c);
        tick();
        repeat (10) tick();
        strobe(9, d);
        repeat (5) tick();
        expect_col(11);
        strobe(11, d);
        wait_tv(c);
        check_eq("c_tvalid_lat", COL_W'(c), COL_W'(t + LAT));
        check_eq("c_ovr", COL_W'(overrun_count), COL_W'(1));
        tick();
        col_if.tready = 1'b1;
        h = cyc;
        tick();
        col_if.tready = 1'b0;
        check_eq("c_b2b_rd_en", COL_W'(mem_rd_en), COL_W'(1'b1));
        check_eq("c_b2b_busy", COL_W'(busy), COL_W'(1'b1));
        check_eq("c_b2b_tvalid", COL_W'(col_if.tvalid), COL_W'(1'b0));
        wait_tv(c);
        check_eq("c_b2b_lat", COL_W'(c), COL_W'(h + LAT));
        check_eq("c_ovr_after", COL_W'(overrun_count), COL_W'(1));

        // Strobe coinciding with the handshake goes straight to FETCH.
        tick();
        expect_col(33);
        theta_in      = TW'(33);
        theta_valid   = 1'b1;
        col_if.tready = 1'b1;
        h = cyc;
        tick();
        theta_valid = 1'b0;
        check_eq("d_rd_en", COL_W'(mem_rd_en), COL_W'(1'b1));
        check_eq("d_tvalid", COL_W'(col_if.tvalid), COL_W'(1'b0));
        check_eq("d_ovr", COL_W'(overrun_count), COL_W'(1));
        wait_tv(c);
        check_eq("d_lat", COL_W'(c), COL_W'(h + LAT));
        tick();

        // Reset at the 40th issue of a fetch, then a clean fetch.
        exp_fetch_q.push_back(50);
        strobe(50, t);
        repeat (39) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_reset_outputs("midrst");
        repeat (10) tick();
        check_eq("e_idle_busy", COL_W'(busy), COL_W'(1'b0));
        check_eq("e_idle_tvalid", COL_W'(col_if.tvalid), COL_W'(1'b0));
        check_eq("e_idle_rd", COL_W'(mem_rd_en), COL_W'(1'b0));
        expect_col(60);
        strobe(60, t);
        wait_rd(c);
        check_eq("e_first_rd", COL_W'(c), COL_W'(t + 1));
        wait_tv(c);
        check_eq("e_tvalid_lat", COL_W'(c), COL_W'(t + LAT));
        tick();

        // Angle range boundaries.
        expect_col(0);
        strobe(0, t);
        wait_tv(c);
        check_eq("f0_lat", COL_W'(c), COL_W'(t + LAT));
        check_eq("f0_last_addr", COL_W'(last_addr), COL_W'(NPIX - 1));
        tick();
        expect_col(ROT - 1);
        strobe(ROT - 1, t);
        wait_tv(c);
        check_eq("fmax_lat", COL_W'(c), COL_W'(t + LAT));
        check_eq("fmax_last_addr", COL_W'(last_addr), COL_W'(ROT * NPIX - 1));
        tick();
        repeat (3) tick();

        check_eq("sb_cols_left", COL_W'(exp_col_q.size()), COL_W'(0));
        check_eq("sb_fetch_left", COL_W'(exp_fetch_q.size()), COL_W'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
